// File: rtl/dmem_access_ctrl.sv
// Y86 memory-stage initiator: decodes one operation, runs a req/gnt/rvalid memory access
// with range check and timeout, and returns ValM/dmem_err over a valid/ready handshake.
module dmem_access_ctrl #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] ValA,
  input  logic [63:0] ValE,
  input  logic [63:0] ValP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ValM,
  output logic        dmem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [63:0]   r_mem_addr;
  logic [63:0]   r_mem_wdata;
  logic          r_out_valid;
  logic [63:0]   r_valm;
  logic          r_err;

  logic          w_is_wr;
  logic          w_is_rd;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic          w_range_err;
  logic          w_accept;
  logic          w_tmo;

  // Operation decode: address/data selection per icode
  always_comb begin
    w_is_wr = 1'b0;
    w_is_rd = 1'b0;
    w_addr  = 64'd0;
    w_wdata = 64'd0;
    case (icode)
      4'd4, 4'd10: begin w_is_wr = 1'b1; w_addr = ValE; w_wdata = ValA; end
      4'd8:        begin w_is_wr = 1'b1; w_addr = ValE; w_wdata = ValP; end
      4'd5:        begin w_is_rd = 1'b1; w_addr = ValE; end
      4'd9, 4'd11: begin w_is_rd = 1'b1; w_addr = ValA; end
      default: ;
    endcase
  end

  // Signed range check: negative means the sign bit is set
  assign w_range_err = w_addr[63] || (w_addr >= 64'(MEM_WORDS));
  assign w_accept    = in_valid && r_in_ready;
  // Budget spans REQ+WAIT combined, so the count keeps running across the gnt
  assign w_tmo       = (r_cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_out_valid <= 1'b0;
      r_valm      <= 64'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready  <= 1'b0;
            r_valm      <= 64'd0;
            r_mem_we    <= w_is_wr;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_cnt       <= '0;
            if (!(w_is_wr || w_is_rd)) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
              r_err       <= 1'b0;
            end else if (w_range_err) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
              r_err       <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
              r_err     <= 1'b0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= CW'(r_cnt + 1'b1);
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_tmo) begin
            r_mem_req   <= 1'b0;
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_err       <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= CW'(r_cnt + 1'b1);
          if (mem_rvalid) begin
            r_valm      <= mem_rdata;
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
          end else if (w_tmo) begin
            r_state     <= S_RESP;
            r_out_valid <= 1'b1;
            r_err       <= 1'b1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign ValM      = r_valm;
  assign dmem_err  = r_err;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: latency, decode, range errors, timeout,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = 4'd0;
  logic [63:0] ValA = 64'd0;
  logic [63:0] ValE = 64'd0;
  logic [63:0] ValP = 64'd0;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] ValM;
  logic        dmem_err;

  int errors = 0;
  int checks = 0;
  int n;

  dmem_access_ctrl #(.MEM_WORDS(1024), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ValA(ValA), .ValE(ValE), .ValP(ValP),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .ValM(ValM), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle; returns in cycle N+1
  task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p);
    check("issue_rdy", 64'(in_ready), 64'd1);
    icode = ic; ValA = a; ValE = e; ValP = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_req",  64'(mem_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_valm", ValM, 64'd0);
    check("rst_err", 64'(dmem_err), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // rmmovq: write granted in the first REQ cycle
    issue(4'd4, 64'h55, 64'd8, 64'd0);
    check("wr_req", 64'(mem_req), 64'd1);
    check("wr_we", 64'(mem_we), 64'd1);
    check("wr_addr", mem_addr, 64'd8);
    check("wr_wdata", mem_wdata, 64'h55);
    check("wr_ov_early", 64'(out_valid), 64'd0);
    check("wr_busy", 64'(in_ready), 64'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("wr_req_drop", 64'(mem_req), 64'd0);
    check("wr_ov", 64'(out_valid), 64'd1);
    check("wr_valm", ValM, 64'd0);
    check("wr_err", 64'(dmem_err), 64'd0);
    check("wr_retire_rdy", 64'(in_ready), 64'd0);
    tick();
    check("wr_ov_clr", 64'(out_valid), 64'd0);
    check("wr_rdy_back", 64'(in_ready), 64'd1);

    // mrmovq: gnt at N+1, rvalid at N+3, result at N+4
    issue(4'd5, 64'd0, 64'd3, 64'd0);
    check("rd_req", 64'(mem_req), 64'd1);
    check("rd_we", 64'(mem_we), 64'd0);
    check("rd_addr", mem_addr, 64'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rd_req_drop", 64'(mem_req), 64'd0);
    check("rd_ov_n2", 64'(out_valid), 64'd0);
    tick();
    check("rd_ov_n3", 64'(out_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'd3;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'd0;
    check("rd_ov", 64'(out_valid), 64'd1);
    check("rd_valm", ValM, 64'd3);
    check("rd_err", 64'(dmem_err), 64'd0);
    tick();

    // nop: immediate response, ValM cleared
    issue(4'd1, 64'd7, 64'd7, 64'd7);
    check("nop_req", 64'(mem_req), 64'd0);
    check("nop_ov", 64'(out_valid), 64'd1);
    check("nop_valm", ValM, 64'd0);
    check("nop_err", 64'(dmem_err), 64'd0);
    tick();

    // call at the top valid address stores ValP
    issue(4'd8, 64'd0, 64'd1023, 64'h40);
    check("call_req", 64'(mem_req), 64'd1);
    check("call_we", 64'(mem_we), 64'd1);
    check("call_addr", mem_addr, 64'd1023);
    check("call_wdata", mem_wdata, 64'h40);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("call_ov", 64'(out_valid), 64'd1);
    check("call_err", 64'(dmem_err), 64'd0);
    tick();

    // ret at MEM_WORDS: range error, no request
    issue(4'd9, 64'd1024, 64'd0, 64'd0);
    check("ret_req", 64'(mem_req), 64'd0);
    check("ret_ov", 64'(out_valid), 64'd1);
    check("ret_err", 64'(dmem_err), 64'd1);
    check("ret_valm", ValM, 64'd0);
    tick();

    // popq at a negative address
    issue(4'd11, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0);
    check("pop_req", 64'(mem_req), 64'd0);
    check("pop_ov", 64'(out_valid), 64'd1);
    check("pop_err", 64'(dmem_err), 64'd1);
    tick();

    // Read granted but never answered: 16 cycles in REQ+WAIT, then error
    out_ready = 1'b0;
    issue(4'd5, 64'd0, 64'd10, 64'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    wait_valid(40, n);
    check("tmo_rd_lat", 64'(n), 64'd15);
    check("tmo_rd_err", 64'(dmem_err), 64'd1);
    check("tmo_rd_valm", ValM, 64'd0);
    check("tmo_rd_req", 64'(mem_req), 64'd0);
    // Held response; late rvalid must not disturb it
    mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_tmo_ov", 64'(out_valid), 64'd1);
      check("bp_tmo_valm", ValM, 64'd0);
      check("bp_tmo_rdy", 64'(in_ready), 64'd0);
    end
    mem_rvalid = 1'b0;
    out_ready = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    check("late_rv_ov", 64'(out_valid), 64'd0);
    check("late_rv_rdy", 64'(in_ready), 64'd1);
    check("late_rv_valm", ValM, 64'd0);

    // Write never granted: mem_req held through N+16, error at N+17
    issue(4'd10, 64'h99, 64'd20, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_wr_req_hold", 64'(mem_req), 64'd1);
    check("tmo_wr_ov_early", 64'(out_valid), 64'd0);
    tick();
    check("tmo_wr_req_drop", 64'(mem_req), 64'd0);
    check("tmo_wr_ov", 64'(out_valid), 64'd1);
    check("tmo_wr_err", 64'(dmem_err), 64'd1);
    tick();

    // Grant in the timeout cycle completes without error
    issue(4'd4, 64'h11, 64'd30, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("edge_ov", 64'(out_valid), 64'd1);
    check("edge_err", 64'(dmem_err), 64'd0);
    tick();

    // Read result held under backpressure
    out_ready = 1'b0;
    issue(4'd5, 64'd0, 64'd100, 64'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 64'h5678;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_valm", ValM, 64'h1234);
      check("bp_rdy", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_ov_clr", 64'(out_valid), 64'd0);

    // Asynchronous reset while requesting
    issue(4'd4, 64'h77, 64'd40, 64'd0);
    check("ar_req_before", 64'(mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", 64'(mem_req), 64'd0);
    check("ar_rdy", 64'(in_ready), 64'd0);
    check("ar_ov", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("ar_idle_rdy", 64'(in_ready), 64'd1);
    check("ar_idle_req", 64'(mem_req), 64'd0);
    check("ar_idle_ov", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
